// File: rtl/buttons_pkg.sv
// buttons_pkg: register offsets and bus mode encodings shared by the
// memory-mapped peripherals (buttons, leds).
package buttons_pkg;

  typedef enum logic [1:0] {
    REG_STATE = 2'd0,
    REG_PRESS = 2'd1,
    REG_MASK  = 2'd2,
    REG_RSVD  = 2'd3
  } reg_off_e;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_RSVD  = 2'b11
  } bus_mode_e;

endpackage

// File: rtl/buttons_debounce.sv
// debounce: two-flop synchronizer plus mismatch counter for one raw input;
// rise_o pulses combinationally on the cycle the stable level goes 0->1.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mismatch, done;

  // the last mismatch cycle commits the new level instead of counting further
  assign mismatch = sync_q[1] ^ stable_q;
  assign done     = mismatch && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign stable_d = done ? sync_q[1] : stable_q;
  assign cnt_d    = (mismatch && !done) ? cnt_q + CW'(1) : '0;
  assign stable_o = stable_q;
  assign rise_o   = done & sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/buttons.sv
// buttons: eight debounced inputs with STATE, W1C PRESS and MASK registers
// on the data bus, and a registered level interrupt.
module buttons
  import buttons_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  data_bus_read,
  input  logic [7:0]  data_bus_write,
  input  logic [31:0] data_bus_addr,
  input  logic        data_bus_select,
  input  logic [1:0]  data_bus_mode,
  input  logic [7:0]  buttons_in,
  output logic        irq
);
  logic [7:0] stable, rise;
  logic [7:0] press_q, press_d, mask_q, mask_d;
  logic       irq_q, irq_d;
  logic       wr;
  logic [1:0] off;
  logic       unused_addr;

  for (genvar i = 0; i < 8; i++) begin : g_db
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (buttons_in[i]),
      .stable_o (stable[i]),
      .rise_o   (rise[i])
    );
  end

  assign off         = data_bus_addr[1:0];
  assign unused_addr = ^data_bus_addr[31:2];
  assign wr          = data_bus_select && (data_bus_mode == MODE_WRITE);
  // OR-ing rise after the clear lets a fresh press win over a same-cycle W1C
  assign press_d = (press_q & ~((wr && off == REG_PRESS) ? data_bus_write : 8'h00)) | rise;
  assign mask_d  = (wr && off == REG_MASK) ? data_bus_write : mask_q;
  assign irq_d   = |(press_q & mask_q);
  assign irq     = irq_q;

  always_comb begin
    data_bus_read = (off == REG_STATE) ? stable :
                    (off == REG_PRESS) ? press_q :
                    (off == REG_MASK)  ? mask_q : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end
endmodule

// File: tb/tb_buttons.sv
// tb_buttons: directed scoreboard bench for buttons with DEBOUNCE_CYCLES = 4;
// expectations are queued with the stimulus and drained against the bus and irq.
module tb_buttons;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_bus_read;
  logic [7:0]  data_bus_write = 8'h00;
  logic [31:0] data_bus_addr = 32'h0;
  logic        data_bus_select = 1'b0;
  logic [1:0]  data_bus_mode = 2'b00;
  logic [7:0]  buttons_in = 8'h00;
  logic        irq;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  buttons #(.DEBOUNCE_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_bus_read   (data_bus_read),
    .data_bus_write  (data_bus_write),
    .data_bus_addr   (data_bus_addr),
    .data_bus_select (data_bus_select),
    .data_bus_mode   (data_bus_mode),
    .buttons_in      (buttons_in),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // sel 0..3 reads that bus offset, sel 4 observes irq
  task automatic expect_v(input string tag, input int sel, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel < 4) begin
        data_bus_addr = 32'h40F4 + 32'(e.sel);
        #1;
        obs = data_bus_read;
      end else begin
        obs = {7'b0, irq};
      end
      n_checks++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %02h expected %02h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic bus_wr(input logic [1:0] off, input logic [7:0] d,
                        input logic sel, input logic [1:0] mode);
    data_bus_addr   = 32'h40F4 + {30'b0, off};
    data_bus_write  = d;
    data_bus_select = sel;
    data_bus_mode   = mode;
    tick(1);
    data_bus_select = 1'b0;
    data_bus_mode   = 2'b00;
  endtask

  initial begin
    #1;
    expect_v("rst_state", 0, 8'h00);
    expect_v("rst_press", 1, 8'h00);
    expect_v("rst_mask", 2, 8'h00);
    expect_v("rst_irq", 4, 8'h00);
    drain();
    tick(2);
    reset = 1'b1;
    tick(3);
    expect_v("idle_state", 0, 8'h00);
    drain();

    // clean press of bit 0: stable exactly 6 edges after the step
    buttons_in = 8'h01;
    tick(5);
    expect_v("lat5_state", 0, 8'h00);
    expect_v("lat5_press", 1, 8'h00);
    drain();
    tick(1);
    expect_v("lat6_state", 0, 8'h01);
    expect_v("lat6_press", 1, 8'h01);
    drain();
    bus_wr(2'd2, 8'h01, 1'b1, 2'b10);
    expect_v("mask_rd", 2, 8'h01);
    expect_v("irq_early", 4, 8'h00);
    drain();
    tick(1);
    expect_v("irq_set", 4, 8'h01);
    drain();

    // short glitch on bit 3
    buttons_in = 8'h09;
    tick(3);
    buttons_in = 8'h01;
    tick(10);
    expect_v("glitch_state", 0, 8'h01);
    expect_v("glitch_press", 1, 8'h01);
    drain();

    // W1C and write qualification
    buttons_in = 8'h05;
    tick(6);
    expect_v("p5_state", 0, 8'h05);
    expect_v("p5_press", 1, 8'h05);
    drain();
    bus_wr(2'd1, 8'h04, 1'b1, 2'b01);
    expect_v("w1c_mode01", 1, 8'h05);
    drain();
    bus_wr(2'd1, 8'h04, 1'b0, 2'b10);
    expect_v("w1c_nosel", 1, 8'h05);
    drain();
    bus_wr(2'd1, 8'h04, 1'b1, 2'b11);
    expect_v("w1c_mode11", 1, 8'h05);
    drain();
    bus_wr(2'd0, 8'hFF, 1'b1, 2'b10);
    expect_v("state_ro", 0, 8'h05);
    drain();
    bus_wr(2'd3, 8'hFF, 1'b1, 2'b10);
    expect_v("off3_zero", 3, 8'h00);
    drain();
    bus_wr(2'd1, 8'h04, 1'b1, 2'b10);
    expect_v("w1c_clr", 1, 8'h01);
    expect_v("w1c_irq", 4, 8'h01);
    drain();

    // set beats a same-cycle clear on bit 2
    buttons_in = 8'h01;
    tick(6);
    expect_v("rel2_state", 0, 8'h01);
    drain();
    buttons_in = 8'h05;
    tick(5);
    expect_v("pre_coll_press", 1, 8'h01);
    drain();
    bus_wr(2'd1, 8'h04, 1'b1, 2'b10);
    expect_v("coll_press", 1, 8'h05);
    expect_v("coll_state", 0, 8'h05);
    drain();
    bus_wr(2'd1, 8'h05, 1'b1, 2'b10);
    expect_v("clrall_press", 1, 8'h00);
    expect_v("clrall_irq_lag", 4, 8'h01);
    drain();
    tick(1);
    expect_v("clrall_irq", 4, 8'h00);
    drain();
    buttons_in = 8'h00;
    tick(6);
    expect_v("fall_state", 0, 8'h00);
    expect_v("fall_press", 1, 8'h00);
    drain();

    // reset mid-debounce of bit 5
    buttons_in = 8'h80;
    tick(6);
    bus_wr(2'd2, 8'h20, 1'b1, 2'b10);
    expect_v("b7_state", 0, 8'h80);
    expect_v("b7_press", 1, 8'h80);
    expect_v("b7_mask", 2, 8'h20);
    drain();
    buttons_in = 8'hA0;
    tick(4);
    expect_v("mid_state", 0, 8'h80);
    drain();
    reset = 1'b0;
    buttons_in = 8'h20;
    #1;
    expect_v("arst_state", 0, 8'h00);
    expect_v("arst_press", 1, 8'h00);
    expect_v("arst_mask", 2, 8'h00);
    expect_v("arst_irq", 4, 8'h00);
    drain();
    tick(1);
    reset = 1'b1;
    tick(5);
    expect_v("post5_state", 0, 8'h00);
    expect_v("post5_press", 1, 8'h00);
    drain();
    tick(1);
    expect_v("post6_state", 0, 8'h20);
    expect_v("post6_press", 1, 8'h20);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/buttons.md
BUTTONS -- requirements
Module: buttons

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clock cycles a synchronized input must hold before it is accepted; legal range 2..2^20.
REQ-002 Port clk, input, 1: system clock; all state updates on rising edge.
REQ-003 Port reset, input, 1: reset, asynchronous, active-low.
REQ-004 Port data_bus_read, output, 8: read data for the register selected by data_bus_addr[1:0].
REQ-005 Port data_bus_write, input, 8: write data.
REQ-006 Port data_bus_addr, input, 32: byte address; only bits [1:0] are decoded (base 0x40F4, offsets 0..3).
REQ-007 Port data_bus_select, input, 1: chip select from the system address decoder.
REQ-008 Port data_bus_mode, input, 2: 00 none, 01 read, 10 write, 11 treated as none.
REQ-009 Port buttons_in, input, 8: raw asynchronous button/switch levels, 1 = pressed.
REQ-010 Port irq, output, 1: level interrupt request.

Function
REQ-011 Each buttons_in bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Each bit SHALL keep a debounced stable level and a mismatch counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-013 Counter SHALL clear on any cycle where synchronized level equals stable level.
REQ-014 Counter SHALL increment on each mismatch cycle; on the DEBOUNCE_CYCLES-th consecutive mismatch cycle the stable level SHALL take the synchronized value and the counter SHALL clear.
REQ-015 Latency from a clean buttons_in step to stable change SHALL be exactly 2 + DEBOUNCE_CYCLES clock cycles.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the stable level.
REQ-017 A 0->1 transition of a stable bit SHALL set the corresponding bit of the press-flag register in the same cycle.
REQ-018 Offset 0 (STATE, read-only) SHALL return the 8 stable levels; writes ignored.
REQ-019 Offset 1 (PRESS, W1C) SHALL return press flags; a write SHALL clear each flag whose data_bus_write bit is 1.
REQ-020 When a set (REQ-017) and a W1C clear hit the same flag in the same cycle, the set SHALL win.
REQ-021 Offset 2 (MASK, read/write) SHALL return the interrupt mask; a write loads data_bus_write.
REQ-022 Offset 3 SHALL read 0x00; writes ignored.
REQ-023 A write SHALL occur only when data_bus_select = 1 and data_bus_mode = 10, taking effect on the next rising clk edge.
REQ-024 data_bus_read SHALL be combinational from data_bus_addr[1:0] and register contents, independent of select/mode; reads have no side effects.
REQ-025 irq SHALL be registered: next-cycle value of |(PRESS & MASK).

Reset
REQ-026 On reset low, synchronizer flops, stable levels, counters, PRESS, MASK and irq SHALL all go to 0 immediately.
REQ-027 After reset release, buttons already held SHALL register as a 0->1 transition after 2 + DEBOUNCE_CYCLES cycles and set PRESS.
REQ-028 Reset mid-debounce SHALL discard partial count; no press flag survives reset.

Structure
REQ-029 Shared package buttons_pkg SHALL hold register offsets (STATE, PRESS, MASK) and bus mode constants (MODE_NONE, MODE_READ, MODE_WRITE), also used by leds.
REQ-030 The single-bit synchronizer + counter + stable level SHALL be sub-module debounce, instantiated 8 times with DEBOUNCE_CYCLES passed through.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 Reset, buttons_in = 0x00 -> STATE 0x00, PRESS 0x00, irq 0.
REQ-032 buttons_in[0] 0->1 held -> STATE bit 0 set exactly 6 cycles later, PRESS = 0x01 the same cycle; MASK = 0x01 -> irq = 1 one cycle later.
REQ-033 buttons_in[3] high for 3 cycles, then low -> STATE and PRESS remain 0x00.
REQ-034 PRESS = 0x05, write 0x04 to offset 1 -> PRESS = 0x01; write with mode 01 or select 0 -> unchanged.
REQ-035 Debounced press of bit 2 coincides with a W1C write of 0x04 -> PRESS bit 2 = 1.
REQ-036 Assert reset while bit 5 counter at 2 -> all registers 0 at once; bit 5 still held -> PRESS = 0x20 at 6 cycles after release.
